// File: rtl/riscv_pipe_pkg.sv
// rtl/riscv_pipe_pkg.sv - shared pipeline control types and forwarding encodings
package riscv_pipe_pkg;

  // Hazard controller FSM: normal issue or multicycle op occupying E
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_MDIV = 1'b1
  } hz_state_e;

  // Operand forwarding select for the E-stage ALU inputs
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // Width of the multicycle down-counter
  localparam int unsigned MDIV_CNT_W = 8;

endpackage

// File: rtl/forward_unit.sv
// rtl/forward_unit.sv - per-operand forwarding select, M result preferred over W
module forward_unit
  import riscv_pipe_pkg::*;
(
  input  logic [4:0] rs_e,
  input  logic [4:0] rd_m,
  input  logic [4:0] rd_w,
  input  logic       regwrite_m,
  input  logic       regwrite_w,
  output logic [1:0] fwd
);

  // Youngest producer wins; x0 is never forwarded since it always reads zero
  always_comb begin
    fwd = FWD_RF;
    if (regwrite_m && (rd_m != 5'd0) && (rd_m == rs_e)) begin
      fwd = FWD_M;
    end else if (regwrite_w && (rd_w != 5'd0) && (rd_w == rs_e)) begin
      fwd = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush/forward control with multicycle op sequencing
module hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned MDIV_CYCLES = 4,
  parameter int unsigned CNTW        = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      rs1_d,
  input  logic [4:0]      rs2_d,
  input  logic [4:0]      rs1_e,
  input  logic [4:0]      rs2_e,
  input  logic [4:0]      rd_e,
  input  logic [4:0]      rd_m,
  input  logic [4:0]      rd_w,
  input  logic            regwrite_m,
  input  logic            regwrite_w,
  input  logic            load_e,
  input  logic            pcsrc_e,
  input  logic            mdiv_e,
  input  logic            mem_req_m,
  input  logic            mem_ready_m,
  output logic            en_f,
  output logic            en_d,
  output logic            clr_d,
  output logic            en_e,
  output logic            clr_e,
  output logic            en_m,
  output logic            clr_m,
  output logic            en_w,
  output logic [1:0]      fwd_a_e,
  output logic [1:0]      fwd_b_e,
  output logic            busy,
  output logic [CNTW-1:0] stall_cycles
);

  // The entry cycle is the first of MDIV_CYCLES, so the counter covers the rest minus the release
  localparam logic [MDIV_CNT_W-1:0] CNT_INIT = MDIV_CNT_W'(MDIV_CYCLES - 2);

  hz_state_e             state_q, state_d;
  logic [MDIV_CNT_W-1:0] cnt_q, cnt_d;
  logic [CNTW-1:0]       stall_q, stall_d;

  logic freeze;
  logic load_use;

  forward_unit u_fwd_a (
    .rs_e       (rs1_e),
    .rd_m       (rd_m),
    .rd_w       (rd_w),
    .regwrite_m (regwrite_m),
    .regwrite_w (regwrite_w),
    .fwd        (fwd_a_e)
  );

  forward_unit u_fwd_b (
    .rs_e       (rs2_e),
    .rd_m       (rd_m),
    .rd_w       (rd_w),
    .regwrite_m (regwrite_m),
    .regwrite_w (regwrite_w),
    .fwd        (fwd_b_e)
  );

  assign freeze   = mem_req_m && !mem_ready_m;
  assign load_use = load_e && (rd_e != 5'd0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

  // Priority resolution: freeze > multicycle > branch flush > load-use > normal
  always_comb begin
    en_f    = 1'b1;
    en_d    = 1'b1;
    en_e    = 1'b1;
    en_m    = 1'b1;
    en_w    = 1'b1;
    clr_d   = 1'b0;
    clr_e   = 1'b0;
    clr_m   = 1'b0;
    state_d = state_q;
    cnt_d   = cnt_q;

    if (freeze) begin
      en_f = 1'b0;
      en_d = 1'b0;
      en_e = 1'b0;
      en_m = 1'b0;
      en_w = 1'b0;
    end else if (state_q == ST_MDIV) begin
      if (cnt_q != '0) begin
        en_f  = 1'b0;
        en_d  = 1'b0;
        en_e  = 1'b0;
        clr_m = 1'b1;
        cnt_d = cnt_q - 1'b1;
      end else begin
        // Release cycle: everything advances and mdiv_e is not looked at
        state_d = ST_RUN;
      end
    end else if (mdiv_e) begin
      en_f    = 1'b0;
      en_d    = 1'b0;
      en_e    = 1'b0;
      clr_m   = 1'b1;
      state_d = ST_MDIV;
      cnt_d   = CNT_INIT;
    end else if (pcsrc_e) begin
      clr_d = 1'b1;
      clr_e = 1'b1;
    end else if (load_use) begin
      en_f  = 1'b0;
      en_d  = 1'b0;
      clr_e = 1'b1;
    end

    stall_d = stall_q + CNTW'(!en_f);
  end

  // State, counter and stall statistic; reset abandons any op in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  assign busy         = (state_q == ST_MDIV);
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic        regwrite_m, regwrite_w, load_e, pcsrc_e, mdiv_e, mem_req_m, mem_ready_m;
  logic        en_f, en_d, clr_d, en_e, clr_e, en_m, clr_m, en_w;
  logic [1:0]  fwd_a_e, fwd_b_e;
  logic        busy;
  logic [31:0] stall_cycles;

  int n_checks;
  int n_errors;

  logic [4:0] en_v;
  logic [2:0] clr_v;
  assign en_v  = {en_f, en_d, en_e, en_m, en_w};
  assign clr_v = {clr_d, clr_e, clr_m};

  hazard_ctrl #(.MDIV_CYCLES(4), .CNTW(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .rs1_d        (rs1_d),
    .rs2_d        (rs2_d),
    .rs1_e        (rs1_e),
    .rs2_e        (rs2_e),
    .rd_e         (rd_e),
    .rd_m         (rd_m),
    .rd_w         (rd_w),
    .regwrite_m   (regwrite_m),
    .regwrite_w   (regwrite_w),
    .load_e       (load_e),
    .pcsrc_e      (pcsrc_e),
    .mdiv_e       (mdiv_e),
    .mem_req_m    (mem_req_m),
    .mem_ready_m  (mem_ready_m),
    .en_f         (en_f),
    .en_d         (en_d),
    .clr_d        (clr_d),
    .en_e         (en_e),
    .clr_e        (clr_e),
    .en_m         (en_m),
    .clr_m        (clr_m),
    .en_w         (en_w),
    .fwd_a_e      (fwd_a_e),
    .fwd_b_e      (fwd_b_e),
    .busy         (busy),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
    regwrite_m = 0; regwrite_w = 0; load_e = 0; pcsrc_e = 0; mdiv_e = 0;
    mem_req_m = 0; mem_ready_m = 0;
  endtask

  // Advance one clock; inputs change and checks run shortly after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clear_inputs();
    reset = 1'b1;
    #2;
    chk("rst_en", en_v, 5'b11111);
    chk("rst_clr", clr_v, 3'b000);
    chk("rst_fwd_a", fwd_a_e, 2'b00);
    chk("rst_fwd_b", fwd_b_e, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_stall", stall_cycles, 32'd0);
    step();
    step();
    reset = 1'b0;
    step();

    // Forwarding
    rd_m = 5; regwrite_m = 1; rs1_e = 5; rd_w = 5; regwrite_w = 1; rs2_e = 3;
    #1;
    chk("fwd_a_m", fwd_a_e, 2'b10);
    chk("fwd_b_none", fwd_b_e, 2'b00);
    rd_m = 0; rs2_e = 5;
    #1;
    chk("fwd_a_w", fwd_a_e, 2'b01);
    chk("fwd_b_w", fwd_b_e, 2'b01);
    regwrite_w = 0;
    #1;
    chk("fwd_a_nowr", fwd_a_e, 2'b00);
    rd_m = 0; rd_w = 0; regwrite_m = 1; regwrite_w = 1; rs1_e = 0;
    #1;
    chk("fwd_a_x0", fwd_a_e, 2'b00);
    chk("norm_en", en_v, 5'b11111);
    clear_inputs();

    // Load-use, one stall cycle
    load_e = 1; rd_e = 7; rs2_d = 7;
    #1;
    chk("lu_en", en_v, 5'b00111);
    chk("lu_clr", clr_v, 3'b010);
    step();
    clear_inputs();
    #1;
    chk("lu_after_en", en_v, 5'b11111);
    chk("lu_stall", stall_cycles, 32'd1);
    load_e = 1; rd_e = 0; rs1_d = 0;
    #1;
    chk("lu_x0_en", en_v, 5'b11111);
    clear_inputs();

    // Load-use overridden by taken branch
    load_e = 1; rd_e = 7; rs1_d = 7; pcsrc_e = 1;
    #1;
    chk("br_en", en_v, 5'b11111);
    chk("br_clr", clr_v, 3'b110);
    step();
    chk("br_stall", stall_cycles, 32'd1);
    clear_inputs();

    // Multicycle op, branch pending alongside it is ignored
    mdiv_e = 1; pcsrc_e = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("md_en_c%0d", c), en_v, 5'b00011);
      chk($sformatf("md_clr_c%0d", c), clr_v, 3'b001);
      chk($sformatf("md_busy_c%0d", c), busy, (c != 0));
      step();
    end
    pcsrc_e = 0;
    #1;
    chk("md_rel_en", en_v, 5'b11111);
    chk("md_rel_busy", busy, 1'b1);
    step();
    mdiv_e = 0;
    #1;
    chk("md_done_busy", busy, 1'b0);
    chk("md_stall", stall_cycles, 32'd4);

    // Memory freeze while cnt==1
    mdiv_e = 1;
    step();
    mdiv_e = 0;
    step();
    mem_req_m = 1; mem_ready_m = 0;
    #1;
    chk("fz_en0", en_v, 5'b00000);
    chk("fz_clr0", clr_v, 3'b000);
    step();
    #1;
    chk("fz_en1", en_v, 5'b00000);
    chk("fz_busy", busy, 1'b1);
    step();
    mem_ready_m = 1;
    #1;
    chk("fz_cnt1_en", en_v, 5'b00011);
    step();
    chk("fz_rel_en", en_v, 5'b11111);
    chk("fz_rel_busy", busy, 1'b1);
    step();
    chk("fz_done_busy", busy, 1'b0);
    chk("fz_stall", stall_cycles, 32'd9);

    // Freeze dominates a branch in RUN
    mem_req_m = 1; mem_ready_m = 0; pcsrc_e = 1;
    #1;
    chk("fzr_en", en_v, 5'b00000);
    chk("fzr_clr", clr_v, 3'b000);
    step();
    chk("fzr_stall", stall_cycles, 32'd10);
    clear_inputs();

    // Reset abandons an op in flight
    mdiv_e = 1;
    step();
    mdiv_e = 0;
    #1;
    chk("rm_busy_pre", busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("rm_busy_async", busy, 1'b0);
    chk("rm_stall_async", stall_cycles, 32'd0);
    step();
    reset = 1'b0;
    step();
    chk("rm_busy", busy, 1'b0);
    chk("rm_en", en_v, 5'b11111);
    chk("rm_stall", stall_cycles, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
